// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared RV32I definitions for the IF/ID boundary: base opcodes, the
// instruction-format enum reported to decode, the skid-buffer occupancy
// states, and a 12-bit sign-extension helper used by the immediate generator.
// -----------------------------------------------------------------------------
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] I_LOAD_OP = 7'd3;
    localparam logic [6:0] I_OP      = 7'd19;
    localparam logic [6:0] U_ADD_OP  = 7'd23;
    localparam logic [6:0] S_OP      = 7'd35;
    localparam logic [6:0] R_OP      = 7'd51;
    localparam logic [6:0] U_LOAD_OP = 7'd55;
    localparam logic [6:0] B_OP      = 7'd99;
    localparam logic [6:0] J_OP      = 7'd111;

    typedef enum logic [2:0] {
        FMT_NONE    = 3'd0,
        FMT_R       = 3'd1,
        FMT_I       = 3'd2,
        FMT_S       = 3'd3,
        FMT_B       = 3'd4,
        FMT_U       = 3'd5,
        FMT_J       = 3'd6,
        FMT_ILLEGAL = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// -----------------------------------------------------------------------------
// if_id_stage_if
// Bundles the IF-side valid/ready channel, the redirect/consume controls and
// the decoded ID-side outputs of the IF/ID boundary.
//   master : fetch/decode environment (drives if_valid, IF_IR, IF_PC, flush,
//            id_ready; observes everything else)
//   slave  : the if_id_stage block itself
// -----------------------------------------------------------------------------
interface if_id_stage_if #(
    parameter int XLEN = 32
);
    import rv_pkg::*;

    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] IF_IR;
    logic [XLEN-1:0] IF_PC;
    logic            flush;
    logic            id_ready;
    logic            id_valid;
    logic [XLEN-1:0] ID_IR;
    logic [XLEN-1:0] ID_PC;
    logic [6:0]      ID_op;
    logic [2:0]      ID_funct3;
    logic [6:0]      ID_funct7;
    logic [4:0]      ID_rs1;
    logic [4:0]      ID_rs2;
    logic [4:0]      ID_rd;
    logic [31:0]     ID_imm;
    fmt_e            ID_fmt;

    modport master (
        output if_valid, IF_IR, IF_PC, flush, id_ready,
        input  if_ready, id_valid, ID_IR, ID_PC, ID_op, ID_funct3, ID_funct7,
               ID_rs1, ID_rs2, ID_rd, ID_imm, ID_fmt
    );

    modport slave (
        input  if_valid, IF_IR, IF_PC, flush, id_ready,
        output if_ready, id_valid, ID_IR, ID_PC, ID_op, ID_funct3, ID_funct7,
               ID_rs1, ID_rs2, ID_rd, ID_imm, ID_fmt
    );

endinterface

// File: rtl/if_id_stage_imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Combinational RV32I immediate extractor and format classifier.
//   ir  : instruction word
//   imm : sign-extended immediate (0 for R-type and unknown opcodes)
//   fmt : instruction format; unknown opcodes report FMT_ILLEGAL
// -----------------------------------------------------------------------------
module imm_gen
    import rv_pkg::*;
(
    input  logic [31:0] ir,
    output logic [31:0] imm,
    output fmt_e        fmt
);

    // Opcode decode into immediate and format.
    always_comb begin
        imm = 32'h0;
        fmt = FMT_ILLEGAL;
        case (ir[6:0])
            I_LOAD_OP, I_OP: begin
                imm = sext12(ir[31:20]);
                fmt = FMT_I;
            end
            S_OP: begin
                imm = sext12({ir[31:25], ir[11:7]});
                fmt = FMT_S;
            end
            B_OP: begin
                // 13-bit branch offset; bit 0 is implicitly zero.
                imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                fmt = FMT_B;
            end
            U_ADD_OP, U_LOAD_OP: begin
                imm = {ir[31:12], 12'h000};
                fmt = FMT_U;
            end
            J_OP: begin
                // 21-bit jump offset; bit 0 is implicitly zero.
                imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
                fmt = FMT_J;
            end
            R_OP: begin
                imm = 32'h0;
                fmt = FMT_R;
            end
            default: begin
                imm = 32'h0;
                fmt = FMT_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
// IF/ID pipeline boundary: a 2-entry skid buffer (main + skid) between fetch
// and decode with valid/ready handshakes, redirect squash, and registered
// decoded fields plus sign-extended immediate.
//   clk      : clock, all state on posedge
//   reset    : asynchronous active-low reset
//   bus      : if_id_stage_if.slave (IF channel, flush, id_ready, ID outputs)
//   stall_cnt, flush_cnt : present only when IF_ID_PERF_CNT_EN is defined
// Optional feature macro: IF_ID_PERF_CNT_EN (stall/flush event counters).
// -----------------------------------------------------------------------------
module if_id_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          reset,
    if_id_stage_if.slave  bus
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt
`endif
);
    import rv_pkg::*;

    occ_e            state_r;
    occ_e            state_s;
    logic            id_valid_r;
    logic            if_ready_r;
    logic            accept_s;
    logic            consume_s;
    logic            load_main_s;
    logic            load_skid_s;
    logic            load_from_skid_s;
    logic [XLEN-1:0] main_ir_r;
    logic [XLEN-1:0] main_pc_r;
    logic [XLEN-1:0] skid_ir_r;
    logic [XLEN-1:0] skid_pc_r;
    logic [XLEN-1:0] load_ir_s;
    logic [XLEN-1:0] load_pc_s;
    logic [31:0]     imm_s;
    logic [31:0]     imm_r;
    fmt_e            fmt_s;
    fmt_e            fmt_r;

    assign accept_s  = bus.if_valid & if_ready_r;
    assign consume_s = id_valid_r & bus.id_ready;

    // Occupancy next-state and load controls; flush overrides every transfer.
    always_comb begin
        state_s          = state_r;
        load_main_s      = 1'b0;
        load_skid_s      = 1'b0;
        load_from_skid_s = 1'b0;
        if (bus.flush) begin
            state_s = OCC_EMPTY;
        end else begin
            case (state_r)
                OCC_EMPTY: begin
                    if (accept_s) begin
                        state_s     = OCC_ONE;
                        load_main_s = 1'b1;
                    end else begin
                        state_s = OCC_EMPTY;
                    end
                end
                OCC_ONE: begin
                    if (consume_s && accept_s) begin
                        state_s     = OCC_ONE;
                        load_main_s = 1'b1;
                    end else if (consume_s) begin
                        state_s = OCC_EMPTY;
                    end else if (accept_s) begin
                        state_s     = OCC_TWO;
                        load_skid_s = 1'b1;
                    end else begin
                        state_s = OCC_ONE;
                    end
                end
                OCC_TWO: begin
                    if (consume_s) begin
                        state_s          = OCC_ONE;
                        load_main_s      = 1'b1;
                        load_from_skid_s = 1'b1;
                    end else begin
                        state_s = OCC_TWO;
                    end
                end
                default: begin
                    state_s = OCC_EMPTY;
                end
            endcase
        end
    end

    // Main entry is refilled from skid when draining TWO, else from IF.
    assign load_ir_s = load_from_skid_s ? skid_ir_r : bus.IF_IR;
    assign load_pc_s = load_from_skid_s ? skid_pc_r : bus.IF_PC;

    imm_gen u_imm_gen (
        .ir  (load_ir_s),
        .imm (imm_s),
        .fmt (fmt_s)
    );

    // Occupancy state with registered valid/ready derived from next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= OCC_EMPTY;
            id_valid_r <= 1'b0;
            if_ready_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            id_valid_r <= (state_s != OCC_EMPTY);
            if_ready_r <= (state_s != OCC_TWO);
        end
    end

    // Main entry and its decode; holds last value while empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_ir_r <= '0;
            main_pc_r <= RESET_PC;
            imm_r     <= 32'h0;
            fmt_r     <= FMT_NONE;
        end else if (load_main_s) begin
            main_ir_r <= load_ir_s;
            main_pc_r <= load_pc_s;
            imm_r     <= imm_s;
            fmt_r     <= fmt_s;
        end else begin
            main_ir_r <= main_ir_r;
            main_pc_r <= main_pc_r;
            imm_r     <= imm_r;
            fmt_r     <= fmt_r;
        end
    end

    // Skid entry captures IF while main is occupied and not draining.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_ir_r <= '0;
            skid_pc_r <= '0;
        end else if (load_skid_s) begin
            skid_ir_r <= bus.IF_IR;
            skid_pc_r <= bus.IF_PC;
        end else begin
            skid_ir_r <= skid_ir_r;
            skid_pc_r <= skid_pc_r;
        end
    end

    assign bus.if_ready  = if_ready_r;
    assign bus.id_valid  = id_valid_r;
    assign bus.ID_IR     = main_ir_r;
    assign bus.ID_PC     = main_pc_r;
    assign bus.ID_op     = main_ir_r[6:0];
    assign bus.ID_funct3 = main_ir_r[14:12];
    assign bus.ID_funct7 = main_ir_r[31:25];
    assign bus.ID_rs1    = main_ir_r[19:15];
    assign bus.ID_rs2    = main_ir_r[24:20];
    assign bus.ID_rd     = main_ir_r[11:7];
    assign bus.ID_imm    = imm_r;
    assign bus.ID_fmt    = fmt_r;

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;
    logic        skid_valid_s;

    assign skid_valid_s = (state_r == OCC_TWO);

    // Event counters: decode back-pressure cycles and flushes of live entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 32'h0;
            flush_cnt_r <= 32'h0;
        end else begin
            stall_cnt_r <= (id_valid_r & ~bus.id_ready) ? stall_cnt_r + 32'd1 : stall_cnt_r;
            flush_cnt_r <= (bus.flush & (id_valid_r | skid_valid_s)) ? flush_cnt_r + 32'd1
                                                                      : flush_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage
// Directed bench for if_id_stage: handshake latency, skid fill/drain order,
// flush squash, immediate decode per format, asynchronous reset and (when
// IF_ID_PERF_CNT_EN is defined) the stall/flush counters.
// -----------------------------------------------------------------------------
module tb_if_id_stage;
    import rv_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    if_id_stage_if #(.XLEN(32)) bus ();

    if_id_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    localparam logic [31:0] IR_I   = {12'd10, 5'd3, 3'b000, 5'd25, I_OP};
    localparam logic [31:0] IR_R   = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, R_OP};
    localparam logic [31:0] IR_S   = {7'b1111111, 5'd2, 5'd1, 3'b010, 5'b11000, S_OP};
    localparam logic [31:0] IR_B   = {7'b1111111, 5'd3, 5'd2, 3'b001, 5'b11101, B_OP};
    localparam logic [31:0] IR_J   = {20'h00200, 5'd1, J_OP};
    localparam logic [31:0] IR_U   = {20'hABCDE, 5'd5, U_LOAD_OP};
    localparam logic [31:0] IR_BAD = {20'hFFFFF, 5'd1, 7'h7F};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks = checks + 1;
        if (obs !== exp_v) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc);
        bus.if_valid = v;
        bus.IF_IR    = ir;
        bus.IF_PC    = pc;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset        = 1'b1;
        bus.if_valid = 1'b0;
        bus.IF_IR    = 32'h0;
        bus.IF_PC    = 32'h0;
        bus.flush    = 1'b0;
        bus.id_ready = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("rst_id_valid", bus.id_valid, 32'd0);
        check("rst_if_ready", bus.if_ready, 32'd1);
        check("rst_ir",       bus.ID_IR,    32'h0);
        check("rst_pc",       bus.ID_PC,    32'h0);
        check("rst_imm",      bus.ID_imm,   32'h0);
        check("rst_fmt",      bus.ID_fmt,   FMT_NONE);
        tick();
        reset = 1'b1;

        // First transfer: one-cycle latency and I-type field decode.
        drive(1'b1, IR_I, 32'd1);
        bus.id_ready = 1'b1;
        tick();
        check("t1_valid",  bus.id_valid,  32'd1);
        check("t1_rd",     bus.ID_rd,     32'd25);
        check("t1_rs1",    bus.ID_rs1,    32'd3);
        check("t1_funct3", bus.ID_funct3, 32'd0);
        check("t1_imm",    bus.ID_imm,    32'd10);
        check("t1_fmt",    bus.ID_fmt,    FMT_I);
        check("t1_pc",     bus.ID_PC,     32'd1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("t1_drain_valid", bus.id_valid, 32'd0);
        check("t1_hold_pc",     bus.ID_PC,    32'd1);
        check("t1_hold_imm",    bus.ID_imm,   32'd10);

        // Skid fill with decode stalled, then in-order drain.
        bus.id_ready = 1'b0;
        drive(1'b1, IR_R, 32'd4);
        tick();
        check("t2_pc4",     bus.ID_PC,     32'd4);
        check("t2_fmt_r",   bus.ID_fmt,    FMT_R);
        check("t2_funct7",  bus.ID_funct7, 32'h20);
        check("t2_rs2",     bus.ID_rs2,    32'd2);
        drive(1'b1, IR_S, 32'd5);
        tick();
        check("t2_full_rdy", bus.if_ready, 32'd0);
        check("t2_full_pc",  bus.ID_PC,    32'd4);
        check("t2_full_vld", bus.id_valid, 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        bus.id_ready = 1'b1;
        tick();
        check("t2_pc5",    bus.ID_PC,    32'd5);
        check("t2_fmt_s",  bus.ID_fmt,   FMT_S);
        check("t2_imm_s",  bus.ID_imm,   32'hFFFFFFF8);
        check("t2_rdy_up", bus.if_ready, 32'd1);
        tick();
        check("t2_empty", bus.id_valid, 32'd0);

        // Flush while full: both entries dropped, offered PC=6 never loaded.
        bus.id_ready = 1'b0;
        drive(1'b1, IR_I, 32'd8);
        tick();
        drive(1'b1, IR_I, 32'd9);
        tick();
        check("t3_full_rdy", bus.if_ready, 32'd0);
        drive(1'b1, IR_I, 32'd6);
        bus.flush = 1'b1;
        tick();
        check("t3_fl_valid", bus.id_valid, 32'd0);
        check("t3_fl_ready", bus.if_ready, 32'd1);
        check("t3_fl_pc",    bus.ID_PC,    32'd8);
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("t3_post_valid", bus.id_valid, 32'd0);

        // Flush in ONE with a same-cycle accept: the accept is discarded.
        drive(1'b1, IR_I, 32'd10);
        tick();
        check("t3b_pc10", bus.ID_PC, 32'd10);
        drive(1'b1, IR_I, 32'd6);
        bus.flush = 1'b1;
        tick();
        check("t3b_fl_valid", bus.id_valid, 32'd0);
        check("t3b_fl_pc",    bus.ID_PC,    32'd10);
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("t3b_post_valid", bus.id_valid, 32'd0);
        check("t3b_post_pc",    bus.ID_PC,    32'd10);

        // Immediate formats through back-to-back consume+accept.
        bus.id_ready = 1'b1;
        drive(1'b1, IR_B, 32'd12);
        tick();
        check("t4_imm_b", bus.ID_imm, 32'hFFFFFFFC);
        check("t4_fmt_b", bus.ID_fmt, FMT_B);
        check("t4_pc_b",  bus.ID_PC,  32'd12);
        drive(1'b1, IR_J, 32'd13);
        tick();
        check("t4_imm_j", bus.ID_imm, 32'd2);
        check("t4_fmt_j", bus.ID_fmt, FMT_J);
        check("t4_pc_j",  bus.ID_PC,  32'd13);
        drive(1'b1, IR_U, 32'd14);
        tick();
        check("t4_imm_u", bus.ID_imm, 32'hABCDE000);
        check("t4_fmt_u", bus.ID_fmt, FMT_U);
        drive(1'b1, IR_BAD, 32'd15);
        tick();
        check("t4_fmt_ill",   bus.ID_fmt,   FMT_ILLEGAL);
        check("t4_imm_ill",   bus.ID_imm,   32'h0);
        check("t4_valid_ill", bus.id_valid, 32'd1);
        check("t4_op_ill",    bus.ID_op,    32'h7F);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("t4_empty", bus.id_valid, 32'd0);

        // Asynchronous reset mid-cycle while full.
        bus.id_ready = 1'b0;
        drive(1'b1, IR_I, 32'd20);
        tick();
        drive(1'b1, IR_S, 32'd21);
        tick();
        check("t5_full_rdy", bus.if_ready, 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        #3 reset = 1'b0;
        #1;
        check("t5_rst_valid", bus.id_valid, 32'd0);
        check("t5_rst_ready", bus.if_ready, 32'd1);
        check("t5_rst_pc",    bus.ID_PC,    32'h0);
        check("t5_rst_ir",    bus.ID_IR,    32'h0);
        check("t5_rst_fmt",   bus.ID_fmt,   FMT_NONE);
        tick();
        reset = 1'b1;

`ifdef IF_ID_PERF_CNT_EN
        // Counters: three stalled cycles, then a flush with decode ready.
        check("pc_stall0", stall_cnt, 32'd0);
        check("pc_flush0", flush_cnt, 32'd0);
        drive(1'b1, IR_I, 32'd30);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        tick();
        check("pc_stall3", stall_cnt, 32'd3);
        bus.flush    = 1'b1;
        bus.id_ready = 1'b1;
        tick();
        check("pc_stall_fl", stall_cnt, 32'd3);
        check("pc_flush1",   flush_cnt, 32'd1);
        bus.flush    = 1'b0;
        bus.id_ready = 1'b0;
        tick();
        check("pc_stall_end", stall_cnt, 32'd3);
        check("pc_flush_end", flush_cnt, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Pipeline boundary between instruction fetch and decode.
- Captures fetched instruction word plus PC through a 2-entry skid buffer with valid/ready handshake.
- Squashes wrong-path instructions on branch/jump redirect.
- Presents registered decoded fields and sign-extended RV32I immediate to ID.

Parameters:
- XLEN, 32, instruction and PC width.
- RESET_PC, 32'h0, ID_PC value held while empty or after reset.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- if_valid  input  1  IF presents a valid instruction.
- if_ready  output  1  stage can accept; registered, equals !skid_valid.
- IF_IR  input  32  fetched instruction.
- IF_PC  input  32  word-indexed PC of IF_IR.
- flush  input  1  redirect; EX_branch_flag | EX_jump_flag.
- id_ready  input  1  decode consumes the entry this cycle.
- id_valid  output  1  ID outputs hold a valid instruction.
- ID_IR  output  32  instruction.
- ID_PC  output  32  its PC.
- ID_op  output  7  IR[6:0].
- ID_funct3  output  3  IR[14:12].
- ID_funct7  output  7  IR[31:25].
- ID_rs1  output  5  IR[19:15].
- ID_rs2  output  5  IR[24:20].
- ID_rd  output  5  IR[11:7].
- ID_imm  output  32  sign-extended immediate.
- ID_fmt  output  3  format enum from the package.

Behaviour:
- Reset (reset=0, asynchronous):
  - id_valid=0, skid_valid=0, if_ready=1.
  - ID_IR=0, ID_PC=RESET_PC, all decoded outputs 0, ID_fmt=FMT_NONE.
  - Reset asserted mid-transfer drops all entries immediately.
- Handshakes:
  - Accept = if_valid & if_ready.
  - Consume = id_valid & id_ready.
  - Latency: accepted instruction appears on the ID outputs the next cycle.
- Occupancy FSM (registered; all transitions at the posedge):
  - EMPTY: accept -> ONE (main loaded).
  - ONE, consume & accept: main reloaded from input; stay ONE.
  - ONE, consume only: -> EMPTY.
  - ONE, accept only: input stored in skid -> TWO; if_ready falls at this edge.
  - TWO, consume: skid moves to main -> ONE; if_ready rises.
  - TWO, no consume: hold.
  - Full: TWO; if_ready=0, so IF must hold PC/IR.
  - Empty: EMPTY; id_valid=0.
- Flush (highest priority after reset):
  - Next state EMPTY; both entries invalidated.
  - Any instruction accepted in the same cycle is discarded.
  - Simultaneous consume is honoured by ID; the entry is still cleared.
  - if_ready=1 the cycle after flush.
- Decode (computed on load into main, so outputs are registered):
  - I_load(3), I(19): FMT_I; imm = sext(IR[31:20]).
  - S(35): FMT_S; imm = sext({IR[31:25], IR[11:7]}).
  - B(99): FMT_B; imm = sext({IR[31], IR[7], IR[30:25], IR[11:8], 0}).
  - U_ADD(23), U_LOAD(55): FMT_U; imm = {IR[31:12], 12'b0}.
  - J(111): FMT_J; imm = sext({IR[31], IR[19:12], IR[20], IR[30:21], 0}).
  - R(51): FMT_R; imm = 0.
  - Other opcode: FMT_ILLEGAL; imm = 0; id_valid still asserted.
- Data outputs hold their last value while id_valid=0.

Optional Feature:
- Macro IF_ID_PERF_CNT_EN.
- Defined: adds output stall_cnt [31:0] and output flush_cnt [31:0].
  - stall_cnt increments on cycles with id_valid & !id_ready.
  - flush_cnt increments on cycles with flush=1 & (id_valid | skid_valid).
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package rv_pkg:
  - Opcode localparams (I_LOAD_OP=3, I_OP=19, U_ADD_OP=23, S_OP=35, R_OP=51, U_LOAD_OP=55, B_OP=99, J_OP=111).
  - fmt_e enum: FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILLEGAL.
  - XLEN default.
- Sub-module imm_gen: combinational IR -> {imm, fmt}; instantiated once on the main-register load path.

Test Plan:
- Reset release, then if_valid=1 with IF_IR={12'd10,5'd3,3'b000,5'd25,I_OP}, IF_PC=1, id_ready=1 -> next cycle id_valid=1, ID_rd=25, ID_rs1=3, ID_imm=10, ID_fmt=FMT_I, ID_PC=1.
- Hold id_ready=0, present PC=4 then PC=5 -> PC=4 in main, PC=5 in skid, if_ready=0; raise id_ready -> consumes PC=4 then PC=5 in order; if_ready=1 after the first consume.
- In state TWO assert flush with if_valid=1 (PC=6) -> next cycle id_valid=0, if_ready=1; PC=6 never appears on ID.
- B instruction {7'b1111111,5'd3,5'd2,3'b001,5'b11101,B_OP} -> ID_imm=32'hFFFFFFFC, ID_fmt=FMT_B; J instruction with IR[31:12]=20'h00200 -> ID_imm=2, ID_fmt=FMT_J.
- Drive reset=0 asynchronously mid-cycle while in state TWO -> id_valid=0 and if_ready=1 without waiting for a clock edge; opcode 7'h7F -> FMT_ILLEGAL, ID_imm=0.
- With IF_ID_PERF_CNT_EN: 3 cycles id_valid=1, id_ready=0, then one flush -> stall_cnt=3, flush_cnt=1.
